breath_led_multi: RTL and testbench

- Parametrised, multi-channel breathing-LED PWM generator; next generation of the single-channel breath block.
- One shared prescaler and PWM frame counter drive NUM_CH independent triangle-ramp brightness channels.
- Per-channel enable and mode select: breath, solid on, off, or slow blink. Adds output polarity, a frame-sync input and end-of-cycle pulses.
- Sits between the board-control register block and the LED pins.

---
 rtl/breath_led_multi.sv | 90 +++++++++
 tb/tb_breath_led_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED PWM generator: a shared prescaler and frame counter
// drive per-channel triangle-ramp brightness with breath/solid/off/blink modes.
module breath_led_multi #(
  parameter int NUM_CH     = 4,
  parameter int DIV_MAX    = 100,
  parameter int STEPS      = 1000,
  parameter int CNT_W      = 10,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic [NUM_CH-1:0]     en,
  input  logic [2*NUM_CH-1:0]   mode,
  output logic [NUM_CH-1:0]     led,
  output logic [NUM_CH-1:0]     done
);

  localparam int DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_MAX - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEPS - 1);
  localparam logic [NUM_CH-1:0] POL       = ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  pwm_cnt;
  logic [CNT_W-1:0]  level [NUM_CH];
  logic [NUM_CH-1:0] dir;
  logic [NUM_CH-1:0] on;
  logic              tick;
  logic              frame_end;

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (pwm_cnt == STEP_LAST);

  always_comb begin
    on = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   on[i] = (pwm_cnt < level[i]);
        2'b01:   on[i] = 1'b1;
        2'b10:   on[i] = 1'b0;
        default: on[i] = ~dir[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      dir     <= '0;
      done    <= '0;
      led     <= POL;
      for (int i = 0; i < NUM_CH; i++) level[i] <= '0;
    end else begin
      // Output always reflects the state before any sync/ramp update this edge.
      led <= (on & en) ^ POL;
      if (sync) begin
        div_cnt <= '0;
        pwm_cnt <= '0;
        dir     <= '0;
        done    <= '0;
        for (int i = 0; i < NUM_CH; i++) level[i] <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) pwm_cnt <= (pwm_cnt == STEP_LAST) ? '0 : pwm_cnt + CNT_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          done[i] <= 1'b0;
          if (!en[i]) begin
            level[i] <= '0;
            dir[i]   <= 1'b0;
          end else if (frame_end) begin
            if (!dir[i]) begin
              if (level[i] == STEP_LAST) dir[i] <= 1'b1;
              else                       level[i] <= level[i] + CNT_W'(1);
            end else begin
              if (level[i] == '0) begin
                dir[i]  <= 1'b0;
                done[i] <= 1'b1;
              end else begin
                level[i] <= level[i] - CNT_W'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_breath_led_multi.sv
// Directed bench for breath_led_multi with DIV_MAX=2, STEPS=4 (8-clk frames, 64-clk
// breath period); an active-low twin instance shares all inputs.
module tb_breath_led_multi;
  logic       clk = 1'b0;
  logic       rst, sync;
  logic [1:0] en;
  logic [3:0] mode;
  logic [1:0] led, done, led_al, done_al;
  int checks = 0;
  int failures = 0;
  int n = 0;

  always #5 clk = ~clk;

  breath_led_multi #(.NUM_CH(2), .DIV_MAX(2), .STEPS(4), .CNT_W(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .sync(sync), .en(en), .mode(mode), .led(led), .done(done));

  breath_led_multi #(.NUM_CH(2), .DIV_MAX(2), .STEPS(4), .CNT_W(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .sync(sync), .en(en), .mode(mode), .led(led_al), .done(done_al));

  // n counts edges since reset release; sampling happens 1 time unit after each edge
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sync = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    n   = 0;
  endtask

  task automatic test_reset();
    en = 2'b11; mode = 4'b0000;
    do_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL reset_led got=%b exp=00", led); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (led_al !== 2'b11) begin failures++; $display("FAIL reset_led_al got=%b exp=11", led_al); end
    checks++; if (done_al !== 2'b00) begin failures++; $display("FAIL reset_done_al got=%b exp=00", done_al); end
    rst = 1'b0;
  endtask

  task automatic test_breath();
    int cnt0 [16];
    int cnt1 [16];
    int cnt_al [16];
    int exp_cnt [8] = '{0, 2, 4, 6, 6, 4, 2, 0};
    logic [1:0] exp_done;
    for (int f = 0; f < 16; f++) begin cnt0[f] = 0; cnt1[f] = 0; cnt_al[f] = 0; end
    en = 2'b11; mode = 4'b0000;
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      step();
      cnt0[(n-1)/8]   += int'(led[0]);
      cnt1[(n-1)/8]   += int'(led[1]);
      cnt_al[(n-1)/8] += int'(led_al[0]);
      exp_done = (n == 64 || n == 128) ? 2'b11 : 2'b00;
      checks++;
      if (done !== exp_done) begin failures++; $display("FAIL breath_done n=%0d got=%b exp=%b", n, done, exp_done); end
    end
    for (int f = 0; f < 16; f++) begin
      checks++;
      if (cnt0[f] != exp_cnt[f%8]) begin failures++; $display("FAIL breath_duty_ch0 frame=%0d got=%0d exp=%0d", f, cnt0[f], exp_cnt[f%8]); end
      checks++;
      if (cnt1[f] != exp_cnt[f%8]) begin failures++; $display("FAIL breath_duty_ch1 frame=%0d got=%0d exp=%0d", f, cnt1[f], exp_cnt[f%8]); end
      checks++;
      if (cnt_al[f] != 8 - exp_cnt[f%8]) begin failures++; $display("FAIL breath_duty_al frame=%0d got=%0d exp=%0d", f, cnt_al[f], 8 - exp_cnt[f%8]); end
    end
  endtask

  task automatic test_modes();
    logic [1:0] exp_led;
    en = 2'b11; mode = 4'b1001;
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      step();
      checks++; if (led !== 2'b01) begin failures++; $display("FAIL mode_solid_off n=%0d got=%b exp=01", n, led); end
      checks++; if (led_al !== 2'b10) begin failures++; $display("FAIL mode_solid_off_al n=%0d got=%b exp=10", n, led_al); end
    end
    mode = 4'b1011;
    for (int k = 32; k <= 96; k++) begin
      step();
      exp_led = {1'b0, (n <= 32 || n >= 65)};
      checks++; if (led !== exp_led) begin failures++; $display("FAIL mode_blink n=%0d got=%b exp=%b", n, led, exp_led); end
    end
  endtask

  task automatic test_enable_restart();
    int c0a = 0, c1a = 0, c0b = 0, c1b = 0;
    logic [1:0] exp_done;
    en = 2'b11; mode = 4'b0000;
    do_reset();
    repeat (34) step();
    en = 2'b01;
    for (int k = 35; k <= 54; k++) begin
      step();
      checks++; if (led[1] !== 1'b0) begin failures++; $display("FAIL en_off_led1 n=%0d got=%b exp=0", n, led[1]); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL en_off_done n=%0d got=%b exp=00", n, done); end
    end
    en = 2'b11;
    for (int k = 55; k <= 128; k++) begin
      step();
      exp_done = {(n == 112), (n == 64 || n == 128)};
      checks++; if (done !== exp_done) begin failures++; $display("FAIL en_restart_done n=%0d got=%b exp=%b", n, done, exp_done); end
      if (n <= 56) begin
        checks++; if (led[1] !== 1'b0) begin failures++; $display("FAIL en_restart_led1 n=%0d got=%b exp=0", n, led[1]); end
      end
      if (n >= 57 && n <= 64) begin c0a += int'(led[0]); c1a += int'(led[1]); end
      if (n >= 73 && n <= 80) begin c0b += int'(led[0]); c1b += int'(led[1]); end
    end
    checks++; if (c1a != 2) begin failures++; $display("FAIL en_restart_ch1_lvl1 got=%0d exp=2", c1a); end
    checks++; if (c1b != 6) begin failures++; $display("FAIL en_restart_ch1_lvl3 got=%0d exp=6", c1b); end
    checks++; if (c0a != 0) begin failures++; $display("FAIL en_restart_ch0_lvl0 got=%0d exp=0", c0a); end
    checks++; if (c0b != 2) begin failures++; $display("FAIL en_restart_ch0_lvl1 got=%0d exp=2", c0b); end
  endtask

  task automatic test_sync();
    int ca = 0, cb = 0;
    logic [1:0] exp_done;
    en = 2'b11; mode = 4'b0000;
    do_reset();
    repeat (23) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL sync_no_done got=%b exp=00", done); end
    for (int k = 25; k <= 88; k++) begin
      step();
      exp_done = (n == 88) ? 2'b11 : 2'b00;
      checks++; if (done !== exp_done) begin failures++; $display("FAIL sync_done n=%0d got=%b exp=%b", n, done, exp_done); end
      if (n >= 25 && n <= 32) ca += int'(led[0]);
      if (n >= 33 && n <= 40) cb += int'(led[0]);
      if (n == 33 || n == 34) begin
        checks++; if (led[0] !== 1'b1) begin failures++; $display("FAIL sync_align n=%0d got=%b exp=1", n, led[0]); end
      end
      if (n == 35) begin
        checks++; if (led[0] !== 1'b0) begin failures++; $display("FAIL sync_align n=%0d got=%b exp=0", n, led[0]); end
      end
    end
    checks++; if (ca != 0) begin failures++; $display("FAIL sync_lvl0 got=%0d exp=0", ca); end
    checks++; if (cb != 2) begin failures++; $display("FAIL sync_lvl1 got=%0d exp=2", cb); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_done;
    en = 2'b11; mode = 4'b0101;
    do_reset();
    repeat (63) step();
    rst = 1'b1;
    step();
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL rst_mid_done got=%b exp=00", done); end
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL rst_mid_led got=%b exp=00", led); end
    checks++; if (led_al !== 2'b11) begin failures++; $display("FAIL rst_mid_led_al got=%b exp=11", led_al); end
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      exp_done = (n == 64) ? 2'b11 : 2'b00;
      checks++; if (done !== exp_done) begin failures++; $display("FAIL rst_mid_restart n=%0d got=%b exp=%b", n, done, exp_done); end
    end
    checks++; if (led !== 2'b11) begin failures++; $display("FAIL rst_mid_solid got=%b exp=11", led); end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; en = 2'b00; mode = 4'b0000;
    test_reset();
    test_breath();
    test_modes();
    test_enable_restart();
    test_sync();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
